blade_pattern_gen: RTL and testbench

Parametrised multi-channel LED pattern generator driving the board LED and a blade header of CHANNELS outputs. Replaces the fixed single-pattern blinker behind the board top. A programmable prescaler produces a step tick that advances one of four selectable patterns: off, blink, chase and bounce. All outputs are registered.

---
 rtl/blade_pattern_gen.sv | 134 +++++++++++++
 tb/tb_blade_pattern_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/blade_pattern_gen.sv
// Multi-channel LED pattern generator: prescaled step tick driving off/blink/chase/bounce on blade and led.
// Optional BLADE_PWM_BREATHE_EN replaces the led toggle with a breathing PWM output.
//
//   state     | meaning
//   DIR_UP    | bounce one-hot (or breathe duty) moving toward its upper end
//   DIR_DOWN  | bounce one-hot (or breathe duty) moving toward its lower end
module blade_pattern_gen #(
  parameter int CHANNELS   = 6,
  parameter int BASE_SHIFT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [3:0]          rate,
  output logic                led,
  output logic [CHANNELS-1:0] blade,
  output logic                step
);

  localparam int CW = BASE_SHIFT + 15;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       term;
  logic [1:0]          mode_q;
  dir_t                dir;
  dir_t                dir_nx;
  logic [CHANNELS-1:0] blade_nx;

`ifdef BLADE_PWM_BREATHE_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty;
  dir_t       duty_dir;
`endif

  // T-1 = 2^(BASE_SHIFT+rate)-1; rate=15 yields the full counter width.
  assign term = {CW{1'b1}} >> (4'd15 - rate);

  always_comb begin
    blade_nx = blade;
    dir_nx   = dir;
    case (mode_q)
      2'd0: blade_nx = '0;
      2'd1: blade_nx = ~blade;
      2'd2: blade_nx = (blade << 1) | (blade >> (CHANNELS - 1));
      default: begin
        if (CHANNELS == 1) begin
          blade_nx = '1;
        end else if (dir == DIR_UP) begin
          if (blade[CHANNELS-1]) begin
            blade_nx = blade >> 1;
            dir_nx   = DIR_DOWN;
          end else begin
            blade_nx = blade << 1;
          end
        end else begin
          if (blade[0]) begin
            blade_nx = blade << 1;
            dir_nx   = DIR_UP;
          end else begin
            blade_nx = blade >> 1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      mode_q   <= 2'd0;
      dir      <= DIR_UP;
      blade    <= '0;
      led      <= 1'b0;
      step     <= 1'b0;
`ifdef BLADE_PWM_BREATHE_EN
      pwm_cnt  <= 8'd0;
      duty     <= 8'd0;
      duty_dir <= DIR_UP;
`endif
    end else begin
      mode_q <= mode;
      step   <= 1'b0;
`ifdef BLADE_PWM_BREATHE_EN
      pwm_cnt <= pwm_cnt + 8'd1;
      led     <= (mode_q != 2'd0) && (pwm_cnt < duty);
`endif
      if (mode != mode_q) begin
        cnt   <= '0;
        dir   <= DIR_UP;
        led   <= 1'b0;
        blade <= (mode[1]) ? CHANNELS'(1) : '0;
`ifdef BLADE_PWM_BREATHE_EN
        duty     <= 8'd0;
        duty_dir <= DIR_UP;
`endif
      end else if (enable) begin
        if (cnt == term) begin
          cnt   <= '0;
          step  <= 1'b1;
          blade <= blade_nx;
          dir   <= dir_nx;
`ifdef BLADE_PWM_BREATHE_EN
          if (duty_dir == DIR_UP) begin
            if (duty == 8'hFF) begin
              duty     <= 8'hFE;
              duty_dir <= DIR_DOWN;
            end else begin
              duty <= duty + 8'd1;
            end
          end else begin
            if (duty == 8'h00) begin
              duty     <= 8'h01;
              duty_dir <= DIR_UP;
            end else begin
              duty <= duty - 8'd1;
            end
          end
`else
          led <= (mode_q == 2'd0) ? 1'b0 : ~led;
`endif
        end else if (cnt > term) begin
          // rate was lowered below the current count: restart quietly
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blade_pattern_gen.sv
// Self-checking bench for blade_pattern_gen (CHANNELS=6, BASE_SHIFT=2), default build.
module tb_blade_pattern_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] rate;
  logic       led;
  logic [5:0] blade;
  logic       step;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] rate;
    int         period;
    logic [5:0] init;
    int         n;
    int         base;
  } vec_t;

  typedef struct {
    logic [5:0] blade;
    logic       led;
  } exp_t;

  vec_t       vecs [4];
  logic [5:0] seqs [23];
  exp_t       sb [$];

  blade_pattern_gen #(.CHANNELS(6), .BASE_SHIFT(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .rate   (rate),
    .led    (led),
    .blade  (blade),
    .step   (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Ticks until step is seen or the bound runs out; ticks returns cycles taken.
  task automatic wait_step(input int bound, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (step !== 1'b1 && ticks < bound);
  endtask

  initial begin
    int   t;
    int   viol;
    logic lexp;
    exp_t e;

    vecs[0] = '{2'd1, 4'd0, 4, 6'h00, 4,  0};
    vecs[1] = '{2'd2, 4'd1, 8, 6'h01, 6,  4};
    vecs[2] = '{2'd3, 4'd0, 4, 6'h01, 11, 10};
    vecs[3] = '{2'd0, 4'd0, 4, 6'h00, 2,  21};
    seqs = '{6'h3F, 6'h00, 6'h3F, 6'h00,
             6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01,
             6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01, 6'h02,
             6'h00, 6'h00};

    reset = 1'b1; enable = 1'b1; mode = 2'd0; rate = 4'd0;
    repeat (3) tick();
    check("rst_blade", 32'(blade), 32'h0);
    check("rst_led",   32'(led),   32'h0);
    check("rst_step",  32'(step),  32'h0);
    reset = 1'b0;
    wait_step(10, t);
    check("first_step_latency", t, 4);

    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      rate = vecs[v].rate;
      tick();
      check("reinit_blade", 32'(blade), 32'(vecs[v].init));
      check("reinit_led",   32'(led),   32'h0);
      check("reinit_step",  32'(step),  32'h0);
      lexp = 1'b0;
      for (int k = 0; k < vecs[v].n; k++) begin
        if (vecs[v].mode != 2'd0) lexp = ~lexp;
        sb.push_back('{seqs[vecs[v].base + k], lexp});
      end
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_step(vecs[v].period + 2, t);
        check("step_interval", t, vecs[v].period);
        e = sb.pop_front();
        check("step_blade", 32'(blade), 32'(e.blade));
        check("step_led",   32'(led),   32'(e.led));
      end
    end

    mode = 2'd2; rate = 4'd0;
    tick();
    check("chase_init", 32'(blade), 32'h01);
    repeat (3) wait_step(6, t);
    check("chase_at_08", 32'(blade), 32'h08);
    repeat (2) tick();
    enable = 1'b0;
    viol = 0;
    repeat (20) begin
      tick();
      if (blade !== 6'h08 || step !== 1'b0) viol++;
    end
    check("freeze_hold", viol, 0);
    enable = 1'b1;
    wait_step(6, t);
    check("resume_remaining", t, 2);
    check("resume_blade", 32'(blade), 32'h10);

    mode = 2'd3; rate = 4'd3;
    tick();
    check("bounce_init", 32'(blade), 32'h01);
    viol = 0;
    repeat (20) begin
      tick();
      if (step !== 1'b0) viol++;
    end
    check("slow_no_step", viol, 0);
    rate = 4'd0;
    tick();
    check("rate_drop_step", 32'(step), 32'h0);
    check("rate_drop_blade", 32'(blade), 32'h01);
    wait_step(8, t);
    check("rate_drop_next", t, 4);
    check("rate_drop_adv", 32'(blade), 32'h02);

    repeat (2) tick();
    mode = 2'd2;
    tick();
    check("midperiod_blade", 32'(blade), 32'h01);
    check("midperiod_step",  32'(step),  32'h0);
    check("midperiod_led",   32'(led),   32'h0);

    mode = 2'd3;
    tick();
    repeat (3) wait_step(6, t);
    check("bounce_pre_rst_blade", 32'(blade), 32'h08);
    check("bounce_pre_rst_led",   32'(led),   32'h1);
    reset = 1'b1;
    tick();
    check("midrst_blade", 32'(blade), 32'h0);
    check("midrst_led",   32'(led),   32'h0);
    check("midrst_step",  32'(step),  32'h0);
    viol = 0;
    repeat (6) begin
      tick();
      if (step !== 1'b0 || blade !== 6'h00) viol++;
    end
    check("rst_overrides_enable", viol, 0);
    reset = 1'b0;
    tick();
    check("post_rst_reinit", 32'(blade), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
